// File: rtl/monopix_pkg.sv
// monopix_pkg: shared readout word layout, timestamp width and gray-code helpers.
package monopix_pkg;
  localparam int DATA_W = 27;
  localparam int TS_W = 6;
  typedef struct packed {
    logic [5:0] col;
    logic [8:0] row;
    logic [TS_W-1:0] le;
    logic [TS_W-1:0] te;
  } t_data;
  typedef enum logic [1:0] {IDLE, ACTIVE, FULL} t_pix_state;
  function automatic logic [TS_W-1:0] bin2gray(input logic [TS_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [TS_W-1:0] gray2bin(input logic [TS_W-1:0] g);
    logic [TS_W-1:0] b;
    b[TS_W-1] = g[TS_W-1];
    for (int i = TS_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/monopix_pixel.sv
// monopix_pixel: one pixel's edge detector, hit FSM and leading/trailing timestamp registers.
module monopix_pixel
  import monopix_pkg::*;
(
  input  logic            clk_bx,
  input  logic            reset,
  input  logic            eff,
  input  logic            clr,
  input  logic [TS_W-1:0] ts,
  output logic            full,
  output logic [TS_W-1:0] le,
  output logic [TS_W-1:0] te
);
  t_pix_state state, nxt;
  logic eff_q;
  logic rise, fall;
  assign rise = eff & ~eff_q;
  assign fall = ~eff & eff_q;
  assign full = state == FULL;
  // a read-clear beats a same-cycle rising edge, so no new hit starts while clearing
  always_comb begin
    nxt = (state == IDLE && rise && !clr) ? ACTIVE :
          (state == ACTIVE && fall)       ? FULL   :
          (state == FULL && clr)          ? IDLE   : state;
  end
  always_ff @(posedge clk_bx or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      eff_q <= 1'b0;
      le <= '0;
      te <= '0;
    end else begin
      state <= nxt;
      eff_q <= eff;
      if (state == IDLE && nxt == ACTIVE) le <= ts;
      if (state == ACTIVE && nxt == FULL) te <= ts;
    end
  end
endmodule

// File: rtl/monopix_top.sv
// monopix_top: pixel matrix with BCID counter, priority arbiter and 27-bit MSB-first serializer.
module monopix_top
  import monopix_pkg::*;
#(
  parameter int NCOL = 4,
  parameter int NROW = 8
) (
  input  logic                 clk_bx,
  input  logic                 reset,
  input  logic                 reset_bcid,
  input  logic [NCOL*NROW-1:0] hit_in,
  input  logic [NCOL*NROW-1:0] pix_en,
  input  logic [NCOL-1:0]      inj_col_sel,
  input  logic [NROW-1:0]      inj_row_sel,
  input  logic                 pulse_n,
  input  logic                 freeze,
  input  logic                 read,
  output logic                 token,
  output logic                 data_out
);
  localparam int NPIX = NCOL * NROW;
  localparam int SW = NPIX > 1 ? $clog2(NPIX) : 1;
  logic [TS_W-1:0] bcid, gray;
  logic [NPIX-1:0] eff, full, clr;
  logic [TS_W-1:0] le_a [NPIX];
  logic [TS_W-1:0] te_a [NPIX];
  logic [SW-1:0] sel, sel_nxt;
  logic read_q, load;
  logic [DATA_W-1:0] shreg;
  t_data word;
  assign gray = bin2gray(bcid);
  assign load = read & ~read_q;
  assign data_out = shreg[DATA_W-1];
  for (genvar c = 0; c < NCOL; c++) begin : g_col
    for (genvar r = 0; r < NROW; r++) begin : g_row
      localparam int I = c * NROW + r;
      assign eff[I] = pix_en[I] & (hit_in[I] | (~pulse_n & inj_col_sel[c] & inj_row_sel[r]));
      assign clr[I] = load & full[I] & (sel == SW'(I));
      monopix_pixel u_pix (
        .clk_bx(clk_bx),
        .reset(reset),
        .eff(eff[I]),
        .clr(clr[I]),
        .ts(gray),
        .full(full[I]),
        .le(le_a[I]),
        .te(te_a[I])
      );
    end
  end
  // flat index is col-major, so the lowest full index is lowest column then lowest row
  always_comb begin
    sel_nxt = '0;
    for (int i = NPIX - 1; i >= 0; i--) if (full[i]) sel_nxt = SW'(i);
  end
  assign word = full[sel] ? {6'(sel / NROW), 9'(sel % NROW), le_a[sel], te_a[sel]} : '0;
  always_ff @(posedge clk_bx or posedge reset) begin
    if (reset) begin
      bcid <= '0;
      sel <= '0;
      token <= 1'b0;
      read_q <= 1'b0;
      shreg <= '0;
    end else begin
      bcid <= reset_bcid ? '0 : bcid + 1'b1;
      sel <= freeze ? sel : sel_nxt;
      token <= |full;
      read_q <= read;
      shreg <= load ? word : shreg << 1;
    end
  end
endmodule

// File: tb/tb_monopix_top.sv
// tb_monopix_top: directed checks of hit capture, arbitration, injection, masking, wrap and reset.
module tb_monopix_top;
  import monopix_pkg::*;
  localparam int NCOL = 4;
  localparam int NROW = 8;
  logic clk_bx = 0;
  logic reset, reset_bcid, pulse_n, freeze, read, token, data_out;
  logic [NCOL*NROW-1:0] hit_in, pix_en;
  logic [NCOL-1:0] inj_col_sel;
  logic [NROW-1:0] inj_row_sel;
  logic [26:0] w, e;
  int checks = 0;
  int failures = 0;

  monopix_top #(.NCOL(NCOL), .NROW(NROW)) dut (
    .clk_bx(clk_bx), .reset(reset), .reset_bcid(reset_bcid), .hit_in(hit_in),
    .pix_en(pix_en), .inj_col_sel(inj_col_sel), .inj_row_sel(inj_row_sel),
    .pulse_n(pulse_n), .freeze(freeze), .read(read), .token(token), .data_out(data_out)
  );

  always #5 clk_bx = ~clk_bx;

  function automatic logic [5:0] g(input int v);
    logic [5:0] b;
    b = 6'(v);
    return b ^ {1'b0, b[5:1]};
  endfunction

  function automatic logic [26:0] mk(input int col, input int row, input int le, input int te);
    return {6'(col), 9'(row), g(le), g(te)};
  endfunction

  task automatic step();
    @(posedge clk_bx);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hit(input logic [NCOL*NROW-1:0] mask, input int start, input int len);
    reset_bcid = 1;
    step();
    reset_bcid = 0;
    repeat (start) step();
    hit_in = mask;
    repeat (len) step();
    hit_in = '0;
    step();
  endtask

  task automatic read_word(output logic [26:0] r);
    read = 1;
    step();
    r[26] = data_out;
    step();
    r[25] = data_out;
    read = 0;
    for (int i = 24; i >= 0; i--) begin
      step();
      r[i] = data_out;
    end
  endtask

  initial begin
    reset = 1; reset_bcid = 0; pulse_n = 1; freeze = 0; read = 0;
    hit_in = '0; pix_en = '1; inj_col_sel = '0; inj_row_sel = '0;
    step(); step();
    reset = 0;
    chk("reset_token", token, 0);
    chk("reset_data", data_out, 0);
    read_word(w);
    chk("empty_read", w, 0);

    hit(32'h1, 5, 8);
    chk("token_latency", token, 0);
    step();
    chk("token_set", token, 1);
    read_word(w);
    chk("single_word", w, mk(0, 0, 5, 13));
    chk("single_le", gray2bin(w[11:6]), 5);
    chk("single_te", gray2bin(w[5:0]), 13);
    chk("single_token_clr", token, 0);
    step();
    chk("tail_zero", data_out, 0);

    hit(32'h0080_0001, 1, 2);
    step();
    read_word(w);
    chk("prio_first", w, mk(0, 0, 1, 3));
    read_word(w);
    chk("prio_second", w, mk(2, 7, 1, 3));
    chk("prio_token_clr", token, 0);

    reset_bcid = 1;
    step();
    reset_bcid = 0;
    repeat (3) step();
    inj_col_sel = 4'b0011; inj_row_sel = 8'h08; pulse_n = 0;
    repeat (4) step();
    pulse_n = 1;
    step(); step();
    chk("inj_token", token, 1);
    read_word(w);
    chk("inj_first", w, mk(0, 3, 3, 7));
    read_word(w);
    chk("inj_second", w, mk(1, 3, 3, 7));
    chk("inj_only_two", token, 0);
    inj_col_sel = '0; inj_row_sel = '0;

    pix_en[5] = 0;
    hit(32'h20, 0, 3);
    step();
    chk("mask_token", token, 0);
    pix_en[5] = 1;
    read_word(w);
    chk("mask_empty", w, 0);

    hit(32'h1, 62, 4);
    step();
    read_word(w);
    chk("wrap_word", w, mk(0, 0, 62, 2));
    chk("wrap_le", gray2bin(w[11:6]), 62);
    chk("wrap_te", gray2bin(w[5:0]), 2);

    hit(32'h200, 2, 3);
    step();
    e = mk(1, 1, 2, 5);
    read = 1;
    step(); step();
    read = 0;
    repeat (15) step();
    chk("midshift_bit10", data_out, 32'(e[10]));
    reset = 1;
    #1;
    chk("async_data", data_out, 0);
    chk("async_token", token, 0);
    #2;
    reset = 0;
    step();
    read_word(w);
    chk("post_reset_idle", w, 0);
    hit(32'h1, 5, 8);
    step();
    read_word(w);
    chk("post_reset_single", w, mk(0, 0, 5, 13));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
